serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB first,
// with a start/busy/done handshake. Results are registered and change only at completion.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, sub_q, busy_q, done_q, cout_q, ovf_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] sr_next;
  logic             carry_msb;
  logic             last;

  always_comb begin
    dsum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // New digit enters from the MSB side; after N digits the LSB digit sits at bit 0.
    sr_next   = WIDTH'({dsum[DIGIT-1:0], sr_q} >> DIGIT);
    // Carry into the top bit of the current digit, recovered from its sum bit.
    carry_msb = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
    last      = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            sub_q   <= sub;
            sr_q    <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          sr_q    <= sr_next;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= sr_next;
            cout_q  <= sub_q ? ~dsum[DIGIT] : dsum[DIGIT];
            ovf_q   <= carry_msb ^ dsum[DIGIT];
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit bit-serial instance plus exhaustive 4-bit/2-digit one.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       start4, cin4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, s4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 8-bit operation with full handshake timing checks.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tc, input logic tsub,
                      input logic [7:0] es, input logic ec, input logic eo);
    logic ok;
    a8 = ta; b8 = tb_; cin8 = tc; sub8 = tsub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    ok = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      if (!(busy8 === 1'b1 && done8 === 1'b0)) ok = 1'b0;
    end
    check({tag, " busy window"}, {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    check({tag, " done edge"}, {done8, busy8, s8, cout8, ovf8}, {1'b1, 1'b0, es, ec, eo});
    @(posedge clk); #1;
    check({tag, " done falls"}, {done8, busy8}, 2'b00);
  endtask

  initial begin
    logic       ok;
    logic       b1;
    int         ia, ib, ic, isub, r, sa, sb, sr;
    logic [3:0] es;
    logic       ec, eo;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
    #12;
    check("reset dut8", {busy8, done8, s8, cout8, ovf8}, '0);
    check("reset dut4", {busy4, done4, s4, cout4, ovf4}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run8("add ff+01",    8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("add 7f+01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run8("add 80+80+1",  8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
    run8("sub 05-07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    run8("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
    run8("sub 10-00-1",  8'h10, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0);

    // Stray starts mid-run are ignored and not queued.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 8)
        check("ignore start result", {done8, s8, cout8, ovf8}, {1'b1, 8'h46, 1'b0, 1'b0});
      start8 = (k == 1 || k == 4);
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b1;
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check("ignore start no queue", {done8, busy8}, 2'b00);

    // Reset mid-run aborts without a done pulse.
    a8 = 8'h33; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async reset clears", {busy8, done8, s8, cout8, ovf8}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 !== 1'b0 || busy8 !== 1'b0) ok = 1'b0;
    end
    check("no done after reset", {31'd0, ok}, 32'd1);
    run8("after reset 7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // Exhaustive 4-bit, two digits, back-to-back with start held through DONE.
    start4 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ib = i & 15; ia = (i >> 4) & 15; ic = (i >> 8) & 1; isub = (i >> 9) & 1;
      a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(isub);
      sa = (ia >= 8) ? ia - 16 : ia;
      sb = (ib >= 8) ? ib - 16 : ib;
      if (isub == 0) begin
        r  = ia + ib + ic;
        sr = sa + sb + ic;
        ec = (r > 15);
      end else begin
        r  = ia - ib - ic;
        sr = sa - sb - ic;
        ec = (r < 0);
      end
      es = 4'(r & 15);
      eo = (sr > 7) || (sr < -8);
      @(posedge clk); #1;
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
      b1 = busy4;
      @(posedge clk); #1;
      check($sformatf("exh a=%0h b=%0h c=%0d sub=%0d", ia, ib, ic, isub),
            {b1, done4, busy4, s4, cout4, ovf4}, {1'b1, 1'b1, 1'b0, es, ec, eo});
    end
    start4 = 1'b0;
    @(posedge clk); #1;
    check("exh idle after stream", {done4, busy4}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
